// File: rtl/debug_trace_uart_tx.sv
// debug_trace_uart_tx: queues {PC, write data} trace records and sends each as a 9-byte UART 8N1 frame
module debug_trace_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Sample_Strobe,
  input  logic [31:0] Debug_PC,
  input  logic [31:0] Debug_WriteData,
  output logic Tx,
  output logic Busy,
  output logic Overflow,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_Count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic [63:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [63:0] shreg;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [3:0] byte_idx;
  logic push, pop, baud_done;
  logic [7:0] cur_byte;
  assign push = Sample_Strobe && Fifo_Count < (AW+1)'(FIFO_DEPTH);
  assign pop = state == LOAD;
  assign baud_done = baud == BW'(CLKS_PER_BIT - 1);
  // byte 0 is the sync marker; record bytes leave from the top of the shift register
  assign cur_byte = byte_idx == 4'd0 ? SYNC_BYTE : shreg[63:56];
  assign Tx = state == START ? 1'b0 : state == DATA ? cur_byte[bit_idx] : 1'b1;
  assign Busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = Fifo_Count != '0 ? LOAD : IDLE;
      LOAD:    state_nx = START;
      START:   state_nx = baud_done ? DATA : START;
      DATA:    state_nx = baud_done && bit_idx == 3'd7 ? STOP : DATA;
      STOP:    state_nx = !baud_done ? STOP : byte_idx != 4'd8 ? START : Fifo_Count != '0 ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge Clk)
    if (push) mem[wr_ptr] <= {Debug_PC, Debug_WriteData};
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Fifo_Count <= '0;
      Overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      Fifo_Count <= Fifo_Count + (AW+1)'(push) - (AW+1)'(pop);
      Overflow <= Overflow | (Sample_Strobe & ~push);
    end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      shreg <= '0;
      baud <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
    end else if (pop) begin
      shreg <= mem[rd_ptr];
      baud <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
    end else if (Busy) begin
      baud <= baud_done ? '0 : baud + BW'(1);
      if (state == DATA && baud_done) bit_idx <= bit_idx + 3'd1;
      if (state == STOP && baud_done && byte_idx != 4'd8) begin
        byte_idx <= byte_idx + 4'd1;
        if (byte_idx != 4'd0) shreg <= shreg << 8;
      end
    end
endmodule

// File: tb/tb_debug_trace_uart_tx.sv
// tb_debug_trace_uart_tx: random and directed trace capture checked against a frame-level model and a UART receiver
module tb_debug_trace_uart_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 90 * CPB;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Sample_Strobe = 1'b0;
  logic [31:0] Debug_PC = '0;
  logic [31:0] Debug_WriteData = '0;
  logic Tx, Busy, Overflow;
  logic [2:0] Fifo_Count;
  debug_trace_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Sample_Strobe(Sample_Strobe), .Debug_PC(Debug_PC),
    .Debug_WriteData(Debug_WriteData), .Tx(Tx), .Busy(Busy), .Overflow(Overflow), .Fifo_Count(Fifo_Count)
  );
  always #5 Clk = ~Clk;
  int checks = 0;
  int failures = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // reference model: record queue plus the schedule of frame start edges
  logic [63:0] mq[$];
  logic [7:0] exp_q[$], rx_q[$];
  logic [7:0] f_bytes [9];
  int cyc = 0, pop_edge = -1, busy_end = -1000, f_start = -1000;
  logic m_ovf = 1'b0;
  logic [7:0] t2_exp [9] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  function automatic void model_reset();
    mq.delete();
    exp_q.delete();
    rx_q.delete();
    pop_edge = -1;
    busy_end = -1000;
    f_start = -1000;
    m_ovf = 1'b0;
  endfunction
  function automatic void model_edge(logic s, logic [63:0] rec);
    logic [63:0] r;
    bit pop, push;
    pop = pop_edge == cyc;
    push = s && mq.size() < DEPTH;
    if (s && !push) m_ovf = 1'b1;
    if (pop) begin
      r = mq.pop_front();
      f_bytes[0] = 8'hA5;
      for (int i = 1; i < 9; i++) f_bytes[i] = r[71-8*i -: 8];
      for (int i = 0; i < 9; i++) exp_q.push_back(f_bytes[i]);
      f_start = cyc;
      busy_end = cyc + FRAME;
      pop_edge = -1;
    end
    if (push) mq.push_back(rec);
    if (pop_edge < 0 && mq.size() > 0) pop_edge = cyc <= busy_end - 1 ? busy_end + 1 : cyc + 2;
  endfunction
  function automatic logic exp_tx();
    int o, b;
    o = cyc - f_start;
    if (o < 0 || o >= FRAME) return 1'b1;
    b = (o % (10 * CPB)) / CPB;
    return b == 0 ? 1'b0 : b == 9 ? 1'b1 : f_bytes[o / (10 * CPB)][b-1];
  endfunction
  function automatic logic exp_busy();
    return (pop_edge >= 0 && cyc >= pop_edge - 1) || cyc < busy_end;
  endfunction
  task automatic step(logic s, logic [31:0] pc, logic [31:0] wd);
    Sample_Strobe = s;
    Debug_PC = pc;
    Debug_WriteData = wd;
    @(posedge Clk);
    cyc++;
    if (Reset_n) model_edge(s, {pc, wd});
    #1;
    check("tx", Tx, exp_tx());
    check("busy", Busy, exp_busy());
    check("overflow", Overflow, m_ovf);
    check("fifo_count", Fifo_Count, mq.size());
  endtask
  task automatic do_reset();
    Reset_n = 1'b0;
    model_reset();
    repeat (3) step(1'b0, '0, '0);
    Reset_n = 1'b1;
  endtask
  task automatic idle_until_done();
    int n = 0;
    while ((pop_edge >= 0 || cyc < busy_end + 2) && n < 6000) begin
      step(1'b0, $urandom, $urandom);
      n++;
    end
  endtask
  task automatic flush_check(string tag);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) check(tag, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask
  // independent UART receiver sampling each bit mid-period
  int dcnt = -1;
  logic [7:0] dsh;
  always @(negedge Clk) begin
    if (!Reset_n) dcnt = -1;
    else if (dcnt < 0) begin
      if (!Tx) dcnt = 0;
    end else begin
      dcnt++;
      if (dcnt % CPB == CPB / 2 && dcnt / CPB >= 1 && dcnt / CPB <= 8) dsh[dcnt/CPB-1] = Tx;
      if (dcnt == 9 * CPB + CPB / 2) begin
        check("stop_bit", Tx, 1'b1);
        rx_q.push_back(dsh);
        dcnt = -1;
      end
    end
  end
  initial begin
    int n;
    logic [31:0] pc_a;
    model_reset();
    repeat (3) step(1'b0, '0, '0);
    check("rst_tx", Tx, 1'b1);
    check("rst_cnt", Fifo_Count, 3'd0);
    Reset_n = 1'b1;
    repeat (2) step(1'b0, '0, '0);
    check("rst_after_tx", Tx, 1'b1);
    check("rst_after_ovf", Overflow, 1'b0);
    step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    step(1'b0, 32'h1234_5678, '0);
    check("t2_lat_hi", Tx, 1'b1);
    step(1'b0, '0, '0);
    check("t2_lat_lo", Tx, 1'b0);
    n = 0;
    while (Busy && n < 1000) begin
      step(1'b0, '0, '0);
      n++;
    end
    check("t2_frame_len", n, FRAME);
    check("t2_count", Fifo_Count, 3'd0);
    step(1'b0, '0, '0);
    check("t2_nbytes_const", rx_q.size(), 9);
    for (int i = 0; i < rx_q.size() && i < 9; i++) check("t2_byte", rx_q[i], t2_exp[i]);
    flush_check("t2");
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, $urandom);
    check("t3_ovf", Overflow, 1'b1);
    check("t3_cnt", Fifo_Count, 3'd4);
    idle_until_done();
    check("t3_ovf_hold", Overflow, 1'b1);
    check("t3_frames", rx_q.size(), 45);
    flush_check("t3");
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, $urandom);
    check("t4_pre_ovf", Overflow, 1'b0);
    check("t4_pre_cnt", Fifo_Count, 3'd4);
    n = 0;
    while (cyc + 1 != pop_edge && n < 2000) begin
      step(1'b0, '0, '0);
      n++;
    end
    step(1'b1, $urandom, $urandom);
    check("t4_ovf", Overflow, 1'b1);
    check("t4_cnt", Fifo_Count, 3'd3);
    idle_until_done();
    flush_check("t4");
    do_reset();
    step(1'b1, $urandom, $urandom);
    n = 0;
    while (cyc != f_start + 13 * CPB + 2 && n < 1000) begin
      step(1'b0, '0, '0);
      n++;
    end
    #2 Reset_n = 1'b0;
    #1;
    check("t5_async_tx", Tx, 1'b1);
    check("t5_async_busy", Busy, 1'b0);
    model_reset();
    repeat (3) step(1'b0, '0, '0);
    Reset_n = 1'b1;
    repeat (50) step(1'b0, '0, '0);
    check("t5_residual", rx_q.size(), 0);
    step(1'b1, $urandom, $urandom);
    idle_until_done();
    flush_check("t5");
    pc_a = $urandom;
    step(1'b1, pc_a, $urandom);
    step(1'b0, ~pc_a, $urandom);
    idle_until_done();
    check("t6_nbytes", rx_q.size(), 9);
    if (rx_q.size() == 9) check("t6_pc", {rx_q[1], rx_q[2], rx_q[3], rx_q[4]}, pc_a);
    flush_check("t6");
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) < 3) || (i % 1000 < 7 && i > 0), $urandom, $urandom);
    idle_until_done();
    flush_check("rand");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
